mem_port_arbiter: RTL and testbench

- Shares one byte-wide 256x8 RAM port between two requesters: instruction fetch (IF, word reads only) and the MEM stage (loads/stores of byte, half-word or word).
- Sequences each access as consecutive single-byte RAM cycles, big-endian: the byte at Address is the MSB.
- Sits between the pipeline's IF/MEM stages and the unified memory array. Replaces direct per-stage memory enables.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/byte_lane_seq.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the IF/MEM byte-port arbiter.
//   state_t      : arbiter sequencing states IDLE -> XFER -> DONE
//   SZ_*         : DmSize encodings
//   owner_t      : which requester holds the current grant
//   size_to_len  : byte count of an access size (illegal size maps to 4,
//                  it never reaches the byte sequencer because it errors out)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_seq.sv
// Byte-lane sequencer: walks one granted access through consecutive
// single-byte RAM cycles, big-endian (byte at the base address is the MSB).
//   clk, srst    : clock, synchronous active-high reset
//   load         : grant strobe; latches base/len/wdata, clears counter and capture
//   step         : one byte cycle is in progress this clock
//   base, len    : start byte address and byte count (1/2/4)
//   wdata        : right-justified store data
//   ram_rdata    : byte returned by the RAM for ram_addr
//   ram_addr     : base + k
//   ram_wdata    : store byte for cycle k
//   last         : current cycle is the final byte (k == len-1)
//   capture_next : capture register with this cycle's read byte shifted in
module byte_lane_seq #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [2:0]        len,
    input  logic [31:0]       wdata,
    input  logic [7:0]        ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              last,
    output logic [31:0]       capture_next
);

    logic [1:0]        k_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [2:0]        len_reg;
    logic [31:0]       wdata_reg;
    // Only three earlier bytes ever need to be held; the fourth arrives live.
    logic [23:0]       capture_reg;

    logic [7:0]        wbytes [4];
    logic [1:0]        sel;

    always_ff @(posedge clk) begin
        if (srst) begin
            k_reg       <= '0;
            base_reg    <= '0;
            len_reg     <= '0;
            wdata_reg   <= '0;
            capture_reg <= '0;
        end else if (load) begin
            k_reg       <= '0;
            base_reg    <= base;
            len_reg     <= len;
            wdata_reg   <= wdata;
            capture_reg <= '0;
        end else if (step) begin
            k_reg       <= k_reg + 2'd1;
            capture_reg <= capture_next[23:0];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
        assign wbytes[gi] = wdata_reg[8*gi +: 8];
    end

    // Byte (len-1-k) counted from the LSB; modulo-4 arithmetic also covers len=4.
    assign sel          = len_reg[1:0] - 2'd1 - k_reg;
    assign ram_wdata    = wbytes[sel];
    assign ram_addr     = base_reg + ADDR_W'(k_reg);
    assign last         = ({1'b0, k_reg} == (len_reg - 3'd1));
    assign capture_next = {capture_reg, ram_rdata};

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one byte-wide RAM port between instruction fetch (word
// reads) and the MEM stage (byte/half/word loads and stores).
//   Clk, Reset                 : clock, synchronous active-high reset
//   IfReq/IfAddr               : fetch request (level, held until IfAck)
//   IfData/IfAck/IfErr         : fetched word, completion pulse, error flag
//   DmReq/DmRW/DmSize/DmAddr/DmWData : data request and store data
//   DmRData/DmAck/DmErr        : load data, completion pulse, error flag
//   RamEn/RamRW/RamAddr/RamWData/RamRData : byte RAM port
//   Busy                       : an access is being sequenced
// DM normally wins; IF is forced through after STARVE_LIMIT consecutive DM
// grants made while it was waiting.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IfReq,
    input  logic [31:0]       IfAddr,
    output logic [31:0]       IfData,
    output logic              IfAck,
    output logic              IfErr,
    input  logic              DmReq,
    input  logic              DmRW,
    input  logic [1:0]        DmSize,
    input  logic [31:0]       DmAddr,
    input  logic [31:0]       DmWData,
    output logic [31:0]       DmRData,
    output logic              DmAck,
    output logic              DmErr,
    output logic              RamEn,
    output logic              RamRW,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [7:0]        RamWData,
    input  logic [7:0]        RamRData,
    output logic              Busy
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t      state_reg;
    owner_t      owner_reg;
    logic        rw_reg;
    logic [7:0]  starve_reg;
    logic        if_ack_reg, if_err_reg, dm_ack_reg, dm_err_reg;
    logic [31:0] if_data_reg, dm_data_reg;

    logic        grant_if, grant_dm, grant_any;
    logic        if_err_chk, dm_err_chk, g_err, g_rw;
    logic [1:0]  g_size;
    logic [ADDR_W-1:0] g_base;
    logic [31:0] g_wdata;

    logic [ADDR_W-1:0] lane_addr;
    logic [7:0]  lane_wbyte;
    logic        lane_last;
    logic [31:0] lane_capture;
    logic        ram_active;

    function automatic logic out_of_range(input logic [31:0] addr);
        return (addr >> ADDR_W) != 32'd0;
    endfunction

    always_comb begin
        grant_if   = IfReq && (!DmReq || (starve_reg == STARVE_MAX));
        grant_dm   = DmReq && !grant_if;
        grant_any  = grant_if || grant_dm;
        if_err_chk = (IfAddr[1:0] != 2'b00) || out_of_range(IfAddr);
        dm_err_chk = (DmSize == SZ_ILLEGAL)
                  || ((DmSize == SZ_HALF) && DmAddr[0])
                  || ((DmSize == SZ_WORD) && (DmAddr[1:0] != 2'b00))
                  || out_of_range(DmAddr);
        g_err      = grant_if ? if_err_chk : dm_err_chk;
        g_rw       = grant_if ? 1'b0 : DmRW;
        g_size     = grant_if ? SZ_WORD : DmSize;
        g_base     = grant_if ? IfAddr[ADDR_W-1:0] : DmAddr[ADDR_W-1:0];
        g_wdata    = grant_if ? 32'd0 : DmWData;
    end

    byte_lane_seq #(
        .ADDR_W (ADDR_W)
    ) u_lane (
        .clk          (Clk),
        .srst         (Reset),
        .load         ((state_reg == IDLE) && grant_any),
        .step         (state_reg == XFER),
        .base         (g_base),
        .len          (size_to_len(g_size)),
        .wdata        (g_wdata),
        .ram_rdata    (RamRData),
        .ram_addr     (lane_addr),
        .ram_wdata    (lane_wbyte),
        .last         (lane_last),
        .capture_next (lane_capture)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_IF;
            rw_reg      <= 1'b0;
            if_ack_reg  <= 1'b0;
            if_err_reg  <= 1'b0;
            dm_ack_reg  <= 1'b0;
            dm_err_reg  <= 1'b0;
            if_data_reg <= '0;
            dm_data_reg <= '0;
        end else begin
            if_ack_reg <= 1'b0;
            if_err_reg <= 1'b0;
            dm_ack_reg <= 1'b0;
            dm_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        owner_reg <= grant_if ? OWN_IF : OWN_DM;
                        rw_reg    <= g_rw;
                        if (g_err) begin
                            // Rejected request: no RAM cycles, complete at once.
                            state_reg <= DONE;
                            if (grant_if) begin
                                if_ack_reg <= 1'b1;
                                if_err_reg <= 1'b1;
                            end else begin
                                dm_ack_reg <= 1'b1;
                                dm_err_reg <= 1'b1;
                            end
                        end else begin
                            state_reg <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (lane_last) begin
                        state_reg <= DONE;
                        if (owner_reg == OWN_IF) begin
                            if_ack_reg <= 1'b1;
                            if (!rw_reg) if_data_reg <= lane_capture;
                        end else begin
                            dm_ack_reg <= 1'b1;
                            if (!rw_reg) dm_data_reg <= lane_capture;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Counts DM grants that IF sat through; any idle IfReq resets the debt.
    always_ff @(posedge Clk) begin
        if (Reset || !IfReq) begin
            starve_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (grant_if)
                starve_reg <= '0;
            else if (grant_dm)
                starve_reg <= starve_reg + 8'd1;
        end
    end

    // RAM strobes are gated by Reset so an abort stops the byte in flight.
    assign ram_active = (state_reg == XFER) && !Reset;
    assign RamEn      = ram_active;
    assign RamRW      = ram_active && rw_reg;
    assign RamAddr    = ram_active ? lane_addr : '0;
    assign RamWData   = (ram_active && rw_reg) ? lane_wbyte : 8'h00;

    assign IfData  = if_data_reg;
    assign IfAck   = if_ack_reg;
    assign IfErr   = if_err_reg;
    assign DmRData = dm_data_reg;
    assign DmAck   = dm_ack_reg;
    assign DmErr   = dm_err_reg;
    assign Busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        IfReq;
    logic [31:0] IfAddr;
    logic [31:0] IfData;
    logic        IfAck;
    logic        IfErr;
    logic        DmReq;
    logic        DmRW;
    logic [1:0]  DmSize;
    logic [31:0] DmAddr;
    logic [31:0] DmWData;
    logic [31:0] DmRData;
    logic        DmAck;
    logic        DmErr;
    logic        RamEn;
    logic        RamRW;
    logic [7:0]  RamAddr;
    logic [7:0]  RamWData;
    logic [7:0]  RamRData;
    logic        Busy;

    mem_port_arbiter #(
        .ADDR_W       (8),
        .STARVE_LIMIT (2)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IfReq    (IfReq),
        .IfAddr   (IfAddr),
        .IfData   (IfData),
        .IfAck    (IfAck),
        .IfErr    (IfErr),
        .DmReq    (DmReq),
        .DmRW     (DmRW),
        .DmSize   (DmSize),
        .DmAddr   (DmAddr),
        .DmWData  (DmWData),
        .DmRData  (DmRData),
        .DmAck    (DmAck),
        .DmErr    (DmErr),
        .RamEn    (RamEn),
        .RamRW    (RamRW),
        .RamAddr  (RamAddr),
        .RamWData (RamWData),
        .RamRData (RamRData),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // RAM device: combinational read, write on the clock edge.
    logic [7:0] ram [256];
    assign RamRData = ram[RamAddr];
    always @(posedge Clk) begin
        if (RamEn === 1'b1 && RamRW === 1'b1) ram[RamAddr] <= RamWData;
    end

    // Behavioural model: expected RAM byte operations and completions, in order.
    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wbyte;
    } ram_op_t;
    typedef struct {
        logic        dm;
        logic        err;
        logic [31:0] data;
    } done_t;

    ram_op_t     op_q[$];
    done_t       done_q[$];
    logic [7:0]  model_mem [256];
    logic [31:0] model_data [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Derive the expected byte traffic and completion of one request.
    task automatic push_model(input logic dm, input logic rw, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int keep, input logic complete);
        int          n;
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  a;
        logic [7:0]  b;
        ram_op_t     op;
        done_t       d;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (size == 2'd1 && addr[0])
           || (size == 2'd2 && addr[1:0] != 2'b00) || (addr > 32'd255);
        rdata = 32'd0;
        if (!err) begin
            for (int k = 0; k < n && k < keep; k++) begin
                a = 8'(addr + 32'(k));
                if (rw) begin
                    b = 8'(wdata >> (8 * (n - 1 - k)));
                    model_mem[a] = b;
                end else begin
                    b = 8'h00;
                end
                rdata = (rdata << 8) | {24'd0, model_mem[a]};
                op.rw = rw;
                op.addr = a;
                op.wbyte = b;
                op_q.push_back(op);
            end
        end
        if (complete) begin
            if (!rw && !err) model_data[dm] = rdata;
            d.dm = dm;
            d.err = err;
            d.data = model_data[dm];
            done_q.push_back(d);
        end
    endtask

    // Single compare process: every cycle, RAM traffic and acks against the model.
    always @(negedge Clk) begin : compare
        ram_op_t op;
        done_t   d;
        if (RamEn === 1'b1) begin
            if (op_q.size() == 0) begin
                check1("ram_unexpected", 1'b1, 1'b0);
            end else begin
                op = op_q.pop_front();
                check("ram_addr", {24'd0, RamAddr}, {24'd0, op.addr});
                check1("ram_rw", RamRW, op.rw);
                if (op.rw) check("ram_wdata", {24'd0, RamWData}, {24'd0, op.wbyte});
            end
        end
        if (IfAck === 1'b1 || DmAck === 1'b1) begin
            check1("ack_single", IfAck & DmAck, 1'b0);
            if (done_q.size() == 0) begin
                check1("ack_unexpected", 1'b1, 1'b0);
            end else begin
                d = done_q.pop_front();
                check1("ack_owner", DmAck, d.dm);
                if (d.dm) begin
                    check1("dm_err", DmErr, d.err);
                    check("dm_rdata", DmRData, d.data);
                    $display("txn DM err=%0b rdata=%h", DmErr, DmRData);
                end else begin
                    check1("if_err", IfErr, d.err);
                    check("if_data", IfData, d.data);
                    $display("txn IF err=%0b data=%h", IfErr, IfData);
                end
            end
        end
    end

    task automatic wait_ack(input logic dm, output int lat);
        logic seen;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 20) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            seen = dm ? (DmAck === 1'b1) : (IfAck === 1'b1);
        end
        if (!seen) begin
            check1("ack_timeout", 1'b0, 1'b1);
            lat = -1;
        end
    endtask

    task automatic wait_any_ack(output logic dm_owner);
        logic seen;
        int   n;
        seen = 1'b0;
        n = 0;
        dm_owner = 1'b0;
        while (!seen && n < 20) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            seen = (IfAck === 1'b1) || (DmAck === 1'b1);
        end
        if (!seen) check1("any_ack_timeout", 1'b0, 1'b1);
        else dm_owner = DmAck;
    endtask

    task automatic run_txn(input logic dm, input logic rw, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat);
        @(posedge Clk);
        #1;
        push_model(dm, rw, size, addr, wdata, 4, 1'b1);
        if (dm) begin
            DmReq = 1'b1; DmRW = rw; DmSize = size; DmAddr = addr; DmWData = wdata;
        end else begin
            IfReq = 1'b1; IfAddr = addr;
        end
        wait_ack(dm, lat);
        if (dm) DmReq = 1'b0;
        else IfReq = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   lat;
        int   idle_n;
        logic owner;
        logic exp_order [6];
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        Reset = 1'b1; IfReq = 1'b0; IfAddr = '0;
        DmReq = 1'b0; DmRW = 1'b0; DmSize = '0; DmAddr = '0; DmWData = '0;
        model_data[0] = '0; model_data[1] = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check1("rst_busy", Busy, 1'b0);
        check1("rst_ramen", RamEn, 1'b0);
        check1("rst_ifack", IfAck, 1'b0);
        check1("rst_dmack", DmAck, 1'b0);
        check("rst_ifdata", IfData, 32'd0);
        check("rst_dmrdata", DmRData, 32'd0);

        // Preload through the port itself.
        run_txn(1'b1, 1'b1, SZ_WORD, 32'h08, 32'hDEADBEEF, lat);
        check("store_word_lat", 32'(lat), 32'd5);
        run_txn(1'b1, 1'b1, SZ_WORD, 32'h0C, 32'h01020304, lat);

        // Word fetch.
        run_txn(1'b0, 1'b0, SZ_WORD, 32'h08, 32'd0, lat);
        check("fetch_lat", 32'(lat), 32'd5);
        check("fetch_data_lit", IfData, 32'hDEADBEEF);
        check1("fetch_err_lit", IfErr, 1'b0);

        // Half store, then byte load.
        run_txn(1'b1, 1'b1, SZ_HALF, 32'h20, 32'h0000ABCD, lat);
        check("half_store_lat", 32'(lat), 32'd3);
        check("mem20_lit", {24'd0, ram[8'h20]}, 32'hAB);
        check("mem21_lit", {24'd0, ram[8'h21]}, 32'hCD);
        run_txn(1'b1, 1'b0, SZ_BYTE, 32'h21, 32'd0, lat);
        check("byte_load_lat", 32'(lat), 32'd2);
        check("byte_load_lit", DmRData, 32'h000000CD);

        // Error cases: misaligned word, out-of-range fetch, illegal size, odd half.
        run_txn(1'b1, 1'b0, SZ_WORD, 32'h22, 32'd0, lat);
        check("err_misalign_lat", 32'(lat), 32'd1);
        check1("err_misalign_lit", DmErr, 1'b1);
        check("err_keeps_rdata", DmRData, 32'h000000CD);
        run_txn(1'b0, 1'b0, SZ_WORD, 32'h100, 32'd0, lat);
        check("err_oor_lat", 32'(lat), 32'd1);
        check1("err_oor_lit", IfErr, 1'b1);
        check("err_keeps_ifdata", IfData, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, SZ_ILLEGAL, 32'h24, 32'd0, lat);
        check1("err_size_lit", DmErr, 1'b1);
        run_txn(1'b1, 1'b1, SZ_HALF, 32'h21, 32'h1234, lat);
        check1("err_half_odd_lit", DmErr, 1'b1);

        // Contention: both held high, expect DM DM IF DM DM IF.
        @(posedge Clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (exp_order[i]) push_model(1'b1, 1'b0, SZ_BYTE, 32'h08, 32'd0, 4, 1'b1);
            else push_model(1'b0, 1'b0, SZ_WORD, 32'h0C, 32'd0, 4, 1'b1);
        end
        DmReq = 1'b1; DmRW = 1'b0; DmSize = SZ_BYTE; DmAddr = 32'h08;
        IfReq = 1'b1; IfAddr = 32'h0C;
        for (int i = 0; i < 6; i++) begin
            wait_any_ack(owner);
            check1($sformatf("grant_order_%0d", i), owner, exp_order[i]);
        end
        DmReq = 1'b0; IfReq = 1'b0;
        check("contend_if_lit", IfData, 32'h01020304);
        check("contend_dm_lit", DmRData, 32'h000000DE);

        // Back-to-back DM with the address changed at the ack.
        @(posedge Clk);
        #1;
        push_model(1'b1, 1'b1, SZ_BYTE, 32'h50, 32'h5A, 4, 1'b1);
        DmReq = 1'b1; DmRW = 1'b1; DmSize = SZ_BYTE; DmAddr = 32'h50; DmWData = 32'h5A;
        wait_ack(1'b1, lat);
        push_model(1'b1, 1'b1, SZ_BYTE, 32'h51, 32'h5B, 4, 1'b1);
        DmAddr = 32'h51; DmWData = 32'h5B;
        idle_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Busy === 1'b1) break;
            idle_n++;
        end
        check("b2b_idle_cycles", 32'(idle_n), 32'd1);
        wait_ack(1'b1, lat);
        DmReq = 1'b0;
        check("mem50_lit", {24'd0, ram[8'h50]}, 32'h5A);
        check("mem51_lit", {24'd0, ram[8'h51]}, 32'h5B);

        // Reset in the middle of a word store, during byte k=2.
        run_txn(1'b1, 1'b1, SZ_HALF, 32'h42, 32'h0000EEFF, lat);
        @(posedge Clk);
        #1;
        push_model(1'b1, 1'b1, SZ_WORD, 32'h40, 32'h11223344, 2, 1'b0);
        DmReq = 1'b1; DmRW = 1'b1; DmSize = SZ_WORD; DmAddr = 32'h40; DmWData = 32'h11223344;
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        check("rst_mid_k2_addr", {24'd0, RamAddr}, 32'h42);
        Reset = 1'b1; DmReq = 1'b0;
        model_data[0] = '0; model_data[1] = '0;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check1("rst_mid_busy", Busy, 1'b0);
        check1("rst_mid_ramen", RamEn, 1'b0);
        check1("rst_mid_dmack", DmAck, 1'b0);
        check("rst_mid_dmrdata", DmRData, 32'd0);
        check("rst_mid_ifdata", IfData, 32'd0);
        check("mem40_lit", {24'd0, ram[8'h40]}, 32'h11);
        check("mem41_lit", {24'd0, ram[8'h41]}, 32'h22);
        check("mem42_lit", {24'd0, ram[8'h42]}, 32'hEE);
        check("mem43_lit", {24'd0, ram[8'h43]}, 32'hFF);

        repeat (4) @(posedge Clk);
        @(negedge Clk);
        check("ops_drained", 32'(op_q.size()), 32'd0);
        check("acks_drained", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
